muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL expose clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL expose rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose start  in  1  request valid this cycle.
REQ-004 SHALL expose op  in  3  muldiv_op_t: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
REQ-005 SHALL expose rs_data  in  32  operand A: dividend, multiplicand, or MTHI/MTLO source, taken from register-file rs read port.
REQ-006 SHALL expose rt_data  in  32  operand B: divisor or multiplier, taken from register-file rt read port.
REQ-007 SHALL expose flush  in  1  abort any in-flight operation.
REQ-008 SHALL expose busy  out  1  division in progress; the pipeline stalls on it.
REQ-009 SHALL expose hi  out  32  HI register.
REQ-010 SHALL expose lo  out  32  LO register.

Function
REQ-011 SHALL have FSM states IDLE, DIV_RUN, DIV_DONE; busy = (state != IDLE), driven from a register with no combinational input path.
REQ-012 SHALL accept a request only when start=1, state=IDLE and flush=0; start while busy is ignored with no side effect.
REQ-013 MULT/MULTU SHALL write {hi,lo} = 64-bit signed/unsigned product at the accepting edge, with busy never asserted.
REQ-014 MTHI/MTLO SHALL write rs_data to hi/lo at the accepting edge, leaving the other register unchanged.
REQ-015 DIV/DIVU accept SHALL capture |A|, |B|, quotient sign and dividend sign, clear the 5-bit iteration counter, and enter DIV_RUN.
REQ-016 DIV_RUN SHALL run restoring division at one quotient bit per cycle, MSB first, with a 33-bit partial remainder, and SHALL go to DIV_DONE after counter value 31.
REQ-017 DIV_DONE SHALL apply signs (quotient negated if signs differ, remainder takes dividend sign), write lo=quotient and hi=remainder, and return to IDLE.
REQ-018 SHALL hold busy high for exactly 33 cycles after a DIV/DIVU accepting edge, with hi/lo updated at the edge that deasserts busy.
REQ-019 SHALL complete a divisor of 0 at the accepting edge with hi/lo unchanged and busy not asserted.
REQ-020 SHALL make signed 0x80000000 / 0xFFFFFFFF yield lo=0x80000000, hi=0, without an exception.
REQ-021 flush=1 in DIV_RUN or DIV_DONE SHALL return the FSM to IDLE next edge with hi/lo unchanged; flush with start in the same cycle SHALL win.
REQ-022 SHALL keep hi/lo stable between writes; outputs are registers only.
REQ-023 SHALL treat MD_NONE with start=1 as a no-op.

Reset
REQ-024 rst=0 SHALL immediately, without a clock edge, force state=IDLE, busy=0, hi=0, lo=0, counter=0 and the divider datapath to 0.
REQ-025 Reset asserted mid-division SHALL discard the operation with no later hi/lo write.
REQ-026 After rst deassertion, the first request SHALL be accepted on the first rising edge.

Structure
REQ-027 muldiv_op_t and the MD_* encodings SHALL live in the shared includes package, with data width via the existing W_DATA macro.
REQ-028 The iterative divider datapath SHALL be sub-module div_iter: operands, step enable and load in; quotient and remainder out. The FSM, sign handling and HI/LO stay in muldiv.
REQ-029 The multiplier SHALL be a single combinational product registered directly into hi/lo, with no extra pipeline stage.

Verification
REQ-030 Reset check: MULTU A=0xFFFFFFFF B=0xFFFFFFFF, then check values; then rst=0 -> hi=0xFFFFFFFE, lo=0x00000001 before reset, hi=lo=0 immediately after reset with no clock edge.
REQ-031 Signed division: DIV A=-7 (0xFFFFFFF9) B=2 -> busy=1 for 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 Divide by zero and overflow: DIVU A=5 B=0 -> busy stays 0, hi/lo unchanged. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 Flush and ignored start: DIV 100/3 started, flush at cycle 10 -> busy=0 next cycle, hi/lo unchanged. A start raised mid-division is ignored.
REQ-034 MTHI/MTLO and MULT: MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> both held. Then MULT -3 x 4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
REQ-035 Async reset mid-division: rst=0 at division cycle 20 -> busy=0 at once, hi=lo=0, no completion write afterward.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op encodings and data width.
`ifndef W_DATA
`define W_DATA 32
`endif

package muldiv_pkg;
  localparam int W     = `W_DATA;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } muldiv_op_t;
endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline and the muldiv unit.
interface muldiv_if;
  import muldiv_pkg::*;
  logic           start;
  muldiv_op_t     op;
  logic [W-1:0]   rs_data;
  logic [W-1:0]   rt_data;
  logic           flush;
  logic           busy;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;

  modport master (output start, op, rs_data, rt_data, flush, input busy, hi, lo);
  modport slave  (input start, op, rs_data, rt_data, flush, output busy, hi, lo);
endinterface

// File: rtl/muldiv_div_iter.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
module div_iter
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);
  logic [W-1:0] rem_q, rem_d, quot_q, quot_d, b_q, b_d;
  logic [W:0]   part;
  logic         ge;

  // quot_q starts as the dividend and shifts quotient bits in from the right
  always_comb begin
    part   = {rem_q, quot_q[W-1]};
    ge     = part >= {1'b0, b_q};
    rem_d  = rem_q;
    quot_d = quot_q;
    b_d    = b_q;
    if (load) begin
      rem_d  = '0;
      quot_d = a;
      b_d    = b;
    end else if (step) begin
      rem_d  = ge ? W'(part - {1'b0, b_q}) : part[W-1:0];
      quot_d = {quot_q[W-2:0], ge};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      b_q    <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      b_q    <= b_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
endmodule

// File: rtl/muldiv.sv
// HI/LO unit: single-cycle multiply and MTHI/MTLO, 33-cycle iterative divide.
module muldiv
  import muldiv_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave md
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qsign_q, qsign_d, rsign_q, rsign_d;
  logic             accept, sgn, a_neg, b_neg, load, step;
  logic [W-1:0]     abs_a, abs_b, quot, rem;
  logic [2*W-1:0]   ext_a, ext_b, prod;

  assign accept = md.start && (state_q == IDLE) && !md.flush;
  assign sgn    = (md.op == MD_MULT) || (md.op == MD_DIV);
  assign a_neg  = sgn && md.rs_data[W-1];
  assign b_neg  = sgn && md.rt_data[W-1];
  assign abs_a  = a_neg ? -md.rs_data : md.rs_data;
  assign abs_b  = b_neg ? -md.rt_data : md.rt_data;
  // sign-extend when signed so the low 2W bits of an unsigned multiply are exact
  assign ext_a  = {{W{a_neg}}, md.rs_data};
  assign ext_b  = {{W{b_neg}}, md.rt_data};
  assign prod   = ext_a * ext_b;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        case (md.op)
          MD_MULT, MD_MULTU: {hi_d, lo_d} = prod;
          MD_MTHI: hi_d = md.rs_data;
          MD_MTLO: lo_d = md.rs_data;
          MD_DIV, MD_DIVU: if (md.rt_data != '0) begin
            load    = 1'b1;
            cnt_d   = '0;
            qsign_d = a_neg ^ b_neg;
            rsign_d = a_neg;
            state_d = DIV_RUN;
          end
          default: ;
        endcase
      end
      DIV_RUN: if (md.flush) state_d = IDLE;
      else begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W-1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = IDLE;
        if (!md.flush) begin
          lo_d = qsign_q ? -quot : quot;
          hi_d = rsign_q ? -rem : rem;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
    end
  end

  div_iter u_div (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (abs_a),
    .b    (abs_b),
    .quot (quot),
    .rem  (rem)
  );

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv with an expected-{hi,lo} scoreboard.
module tb_muldiv;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_if mif();
  muldiv dut (.clk(clk), .rst(rst), .md(mif));

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sbq[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_model();
    sbq.push_back({m_hi, m_lo});
  endtask

  task automatic sb_check(input string tag);
    logic [63:0] e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_hi"}, mif.hi, e[63:32]);
      chk({tag, "_lo"}, mif.lo, e[31:0]);
    end
  endtask

  // drive a one-cycle request starting at the current negedge
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    mif.start = 1'b1; mif.op = op; mif.rs_data = a; mif.rt_data = b;
    @(negedge clk);
    mif.start = 1'b0; mif.op = MD_NONE;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (mif.busy !== 1'b0 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    mif.start = 1'b0; mif.op = MD_NONE; mif.rs_data = '0; mif.rt_data = '0; mif.flush = 1'b0;
    #1;
    chk("rst_hi", mif.hi, 32'h0);
    chk("rst_lo", mif.lo, 32'h0);
    chk("rst_busy", {31'b0, mif.busy}, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001; push_model();
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_busy", {31'b0, mif.busy}, 32'h0);
    sb_check("multu");

    // asynchronous reset between clock edges
    #1 rst = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; push_model();
    sb_check("async_rst");

    @(negedge clk);
    rst = 1'b1;
    m_hi = 32'h12345678; push_model();
    issue(MD_MTHI, 32'h12345678, 32'h0);
    sb_check("mthi");
    m_lo = 32'h9ABCDEF0; push_model();
    issue(MD_MTLO, 32'h9ABCDEF0, 32'h0);
    sb_check("mtlo");
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFF4; push_model();
    issue(MD_MULT, 32'hFFFFFFFD, 32'h4);
    sb_check("mult");

    // signed divide -7 / 2
    issue(MD_DIV, 32'hFFFFFFF9, 32'h2);
    chk("div_lo_held", mif.lo, 32'hFFFFFFF4);
    wait_idle(n);
    chk("div_busy_cycles", n, 32'd33);
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD; push_model();
    sb_check("div_neg7_2");

    // divide by zero: no state change
    push_model();
    issue(MD_DIVU, 32'h5, 32'h0);
    chk("div0_busy", {31'b0, mif.busy}, 32'h0);
    sb_check("div0");

    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("ovf_cycles", n, 32'd33);
    m_hi = 32'h0; m_lo = 32'h80000000; push_model();
    sb_check("ovf");

    // flush at cycle 10 with an ignored start at cycle 5
    push_model();
    issue(MD_DIV, 32'd100, 32'd3);
    repeat (4) @(negedge clk);
    issue(MD_MULTU, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    mif.flush = 1'b1;
    @(negedge clk);
    mif.flush = 1'b0;
    chk("flush_busy", {31'b0, mif.busy}, 32'h0);
    sb_check("flush");
    repeat (40) @(negedge clk);
    push_model();
    sb_check("flush_late");

    // flush beats a simultaneous start
    mif.flush = 1'b1;
    issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
    mif.flush = 1'b0;
    push_model();
    sb_check("flush_start");

    issue(MD_DIVU, 32'd100, 32'd3);
    wait_idle(n);
    m_hi = 32'd1; m_lo = 32'd33; push_model();
    sb_check("divu_100_3");

    issue(MD_DIV, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    m_hi = 32'd1; m_lo = 32'hFFFFFFFD; push_model();
    sb_check("div_7_neg2");

    // reset at division cycle 20 discards the operation
    issue(MD_DIV, 32'd100, 32'd3);
    repeat (19) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rstdiv_busy", {31'b0, mif.busy}, 32'h0);
    m_hi = '0; m_lo = '0; push_model();
    sb_check("rstdiv");
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstdiv_late_busy", {31'b0, mif.busy}, 32'h0);
    push_model();
    sb_check("rstdiv_late");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
